// File: rtl/ialu_sum_arb_pkg.sv
// ialu_sum_arb_pkg
// Shared types and constants for the IALU adder arbiter:
//   SUM_CMD_ADD / SUM_CMD_SUB : cmd encoding seen by the shared adder
//   SUM_CNT_W                 : width of the optional statistics counters
//   sum_res_t                 : registered adder result (res, carry, ovf, flags)
//   sum_state_e               : result-stage FSM state
//   sat_inc                   : saturating increment for the counters
package ialu_sum_arb_pkg;

  localparam logic SUM_CMD_ADD = 1'b1;
  localparam logic SUM_CMD_SUB = 1'b0;

  localparam int SUM_CNT_W = 16;

  typedef struct packed {
    logic [31:0] res;
    logic        carry;
    logic        pos_ovf;
    logic        neg_ovf;
    logic [3:0]  flags;
  } sum_res_t;

  typedef enum logic {
    SUM_EMPTY = 1'b0,
    SUM_FULL  = 1'b1
  } sum_state_e;

  function automatic logic [SUM_CNT_W-1:0] sat_inc(input logic [SUM_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adder.sv
// adder
// IALU main adder. cmd=1 adds, cmd=0 computes op1 - op2 as op1 + ~op2 + 1.
// Ports:
//   op1, op2 : 32-bit operands
//   cmd      : 1 = add, 0 = subtract
//   sum      : 33-bit result, sum[32] is carry-out (no-borrow on subtract)
//   pos_ovf  : signed overflow towards positive (two non-negatives gave negative)
//   neg_ovf  : signed overflow towards negative (two negatives gave non-negative)
//   flags    : {N, Z, C, V}
module adder (
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        cmd,
  output logic [32:0] sum,
  output logic        pos_ovf,
  output logic        neg_ovf,
  output logic [3:0]  flags
);

  logic [31:0] op2_eff;

  assign op2_eff = cmd ? op2 : ~op2;
  assign sum     = {1'b0, op1} + {1'b0, op2_eff} + {32'b0, ~cmd};

  // Overflow judged on the effective (possibly inverted) second operand.
  assign pos_ovf = ~op1[31] & ~op2_eff[31] &  sum[31];
  assign neg_ovf =  op1[31] &  op2_eff[31] & ~sum[31];

  assign flags = {sum[31], (sum[31:0] == 32'h0), sum[32], pos_ovf | neg_ovf};

endmodule

// File: rtl/ialu_sum_rr_pick.sv
// ialu_sum_rr_pick
// Combinational round-robin pick: searches req valids starting at ptr+1
// (mod NREQ) and returns the first valid one.
// Ports:
//   valid : per-requester valid
//   ptr   : index of the last granted requester
//   grant : one-hot grant (all zero when nothing is valid)
//   idx   : binary index of the granted requester (0 when none)
//   any   : at least one requester is valid
module ialu_sum_rr_pick #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && valid[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/ialu_sum_arb.sv
// ialu_sum_arb
// Shares the single IALU adder among NREQ requesters with a round-robin
// arbiter and registers one result per cycle into a one-entry result stage.
// Optional statistics counters are built only when SUM_ARB_STATS_EN is defined.
//
// Handshake: a transfer happens on a port when its valid and ready are both
// high at a rising clock edge; ready may depend combinationally on valid
// (requests) and on rsp_ready (response), never on operand data.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_valid/ready  : per-requester request handshake
//   req_op1/op2/cmd  : per-requester operands and cmd (1 add, 0 sub)
//   rsp_valid/ready  : result handshake
//   rsp_id           : owner of the held result
//   rsp_res/carry    : sum[31:0] / sum[32]
//   rsp_pos/neg_ovf  : adder overflow flags
//   rsp_flags        : adder {N,Z,C,V}
//   dbg_state        : result-stage FSM state
//   stat_grant_cnt   : per-requester saturating grant counters (stats only)
//   stat_stall_cnt   : saturating back-pressure stall counter (stats only)
module ialu_sum_arb
  import ialu_sum_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0][31:0] req_op1,
  input  logic [NREQ-1:0][31:0] req_op2,
  input  logic [NREQ-1:0]       req_cmd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [31:0]           rsp_res,
  output logic                  rsp_carry,
  output logic                  rsp_pos_ovf,
  output logic                  rsp_neg_ovf,
  output logic [3:0]            rsp_flags,
  output sum_state_e            dbg_state
`ifdef SUM_ARB_STATS_EN
  ,
  output logic [NREQ-1:0][SUM_CNT_W-1:0] stat_grant_cnt,
  output logic [SUM_CNT_W-1:0]           stat_stall_cnt
`endif
);

  sum_state_e      state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            any_valid;
  logic            adv;
  logic            xfer;

  logic [31:0]     add_op1, add_op2;
  logic            add_cmd;
  logic [32:0]     add_sum;
  logic            add_pos_ovf, add_neg_ovf;
  logic [3:0]      add_flags;

  sum_res_t        res_d, res_q;

  ialu_sum_rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any_valid)
  );

  assign rsp_valid = (state == SUM_FULL);
  assign adv       = !rsp_valid | rsp_ready;
  // Gating with rst_n keeps ready low while reset is held, even though the
  // stage already reads EMPTY.
  assign req_ready = (adv && rst_n) ? grant : '0;
  assign xfer      = adv & any_valid & rst_n;

  assign add_op1 = req_op1[gidx];
  assign add_op2 = req_op2[gidx];
  assign add_cmd = req_cmd[gidx];

  adder u_adder (
    .op1     (add_op1),
    .op2     (add_op2),
    .cmd     (add_cmd),
    .sum     (add_sum),
    .pos_ovf (add_pos_ovf),
    .neg_ovf (add_neg_ovf),
    .flags   (add_flags)
  );

  always_comb begin
    res_d         = '0;
    res_d.res     = add_sum[31:0];
    res_d.carry   = add_sum[32];
    res_d.pos_ovf = add_pos_ovf;
    res_d.neg_ovf = add_neg_ovf;
    res_d.flags   = add_flags;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SUM_EMPTY: if (xfer) state_nxt = SUM_FULL;
      SUM_FULL: begin
        if (xfer)           state_nxt = SUM_FULL;
        else if (rsp_ready) state_nxt = SUM_EMPTY;
      end
      default: state_nxt = SUM_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SUM_EMPTY;
      ptr    <= IDW'(NREQ - 1);
      res_q  <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        ptr    <= gidx;
        res_q  <= res_d;
        rsp_id <= gidx;
      end
    end
  end

  assign rsp_res     = res_q.res;
  assign rsp_carry   = res_q.carry;
  assign rsp_pos_ovf = res_q.pos_ovf;
  assign rsp_neg_ovf = res_q.neg_ovf;
  assign rsp_flags   = res_q.flags;
  assign dbg_state   = state;

`ifdef SUM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (xfer && grant[i]) stat_grant_cnt[i] <= sat_inc(stat_grant_cnt[i]);
      end
      if (rsp_valid && !rsp_ready && |req_valid) stat_stall_cnt <= sat_inc(stat_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ialu_sum_arb.sv
// tb_ialu_sum_arb
// Directed bench for ialu_sum_arb (NREQ=2). Covers reset values, add/sub
// vectors with hand-computed results and flags, round-robin order, result
// hold under back-pressure with back-to-back reload, asynchronous reset, and
// (with SUM_ARB_STATS_EN) the statistics counters including saturation.
module tb_ialu_sum_arb;
  import ialu_sum_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = $clog2(NREQ);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_op1;
  logic [NREQ-1:0][31:0] req_op2;
  logic [NREQ-1:0]       req_cmd;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_res;
  logic                  rsp_carry;
  logic                  rsp_pos_ovf;
  logic                  rsp_neg_ovf;
  logic [3:0]            rsp_flags;
  sum_state_e            dbg_state;
`ifdef SUM_ARB_STATS_EN
  logic [NREQ-1:0][SUM_CNT_W-1:0] stat_grant_cnt;
  logic [SUM_CNT_W-1:0]           stat_stall_cnt;
`endif

  ialu_sum_arb #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_cmd     (req_cmd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_res     (rsp_res),
    .rsp_carry   (rsp_carry),
    .rsp_pos_ovf (rsp_pos_ovf),
    .rsp_neg_ovf (rsp_neg_ovf),
    .rsp_flags   (rsp_flags),
    .dbg_state   (dbg_state)
`ifdef SUM_ARB_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Lone request from one requester; result checked one cycle later.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic cmd, input logic [31:0] er, input logic ec,
                       input logic ep, input logic en, input logic [3:0] ef);
    logic [NREQ-1:0] er_ready;
    er_ready     = '0;
    er_ready[id] = 1'b1;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_op1[id]   = a;
    req_op2[id]   = b;
    req_cmd[id]   = cmd;
    rsp_ready     = 1'b1;
    #1 check("issue_ready", req_ready, er_ready);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("issue_valid", rsp_valid, 1);
    check("issue_id", rsp_id, id);
    check("issue_res", rsp_res, er);
    check("issue_carry", rsp_carry, ec);
    check("issue_pos_ovf", rsp_pos_ovf, ep);
    check("issue_neg_ovf", rsp_neg_ovf, en);
    check("issue_flags", rsp_flags, ef);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_valid = '1;
    req_op1   = '0;
    req_op2   = '0;
    req_cmd   = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset values with requests pending: nothing may be accepted.
    @(posedge clk);
    #1;
    check("rst_valid", rsp_valid, 0);
    check("rst_id", rsp_id, 0);
    check("rst_res", rsp_res, 0);
    check("rst_flags", {rsp_carry, rsp_pos_ovf, rsp_neg_ovf, rsp_flags}, 0);
    check("rst_ready", req_ready, 0);
    check("rst_state", dbg_state, SUM_EMPTY);
    do_reset();

    // Directed add/sub vectors: id, op1, op2, cmd, res, carry, pos, neg, {N,Z,C,V}
    issue(0, 32'd1,        32'd2, SUM_CMD_ADD, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 4'b0000);
    issue(1, 32'd5,        32'd3, SUM_CMD_SUB, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 4'b0010);
    issue(1, 32'd0,        32'd1, SUM_CMD_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'b1000);
    issue(0, 32'h7FFF_FFFF, 32'd1, SUM_CMD_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 4'b1001);
    issue(1, 32'h8000_0000, 32'd1, SUM_CMD_SUB, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 4'b0011);
    issue(0, 32'd5,        32'd5, SUM_CMD_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b0110);
    issue(1, 32'hFFFF_FFFF, 32'd1, SUM_CMD_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b0110);

    // Round-robin with both requesters valid: 0,1,0,1 after reset.
    do_reset();
    req_op1[0] = 32'd10; req_op2[0] = 32'd0; req_cmd[0] = SUM_CMD_ADD;
    req_op1[1] = 32'd20; req_op2[1] = 32'd0; req_cmd[1] = SUM_CMD_ADD;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? 64'd10 : 64'd20);
      #1 check("rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1;
      check("rr_id", rsp_id, k % 2);
      check("rr_res", rsp_res, exp_q.pop_front());
    end

    // Back-pressure: result from requester 1 held for 3 cycles.
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("hold_ready", req_ready, 0);
      check("hold_valid", rsp_valid, 1);
      check("hold_id", rsp_id, 1);
      check("hold_res", rsp_res, 20);
      check("hold_state", dbg_state, SUM_FULL);
      @(posedge clk);
      #1;
    end
    // Releasing back-pressure reloads in the same cycle (next is requester 0).
    rsp_ready = 1'b1;
    #1 check("reload_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("reload_valid", rsp_valid, 1);
    check("reload_id", rsp_id, 0);
    check("reload_res", rsp_res, 10);

    // Asynchronous reset while FULL; pointer returns to favour requester 0
    // (without reset it would now favour requester 1).
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", rsp_valid, 0);
    check("ar_res", rsp_res, 0);
    check("ar_state", dbg_state, SUM_EMPTY);
    @(posedge clk);
    #2 rst_n = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1 check("ar_ready", req_ready, 2'b01);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("ar_first_id", rsp_id, 0);
    check("ar_first_valid", rsp_valid, 1);

`ifdef SUM_ARB_STATS_EN
    do_reset();
    check("st_rst_grant0", stat_grant_cnt[0], 0);
    check("st_rst_stall", stat_stall_cnt, 0);
    issue(0, 32'd1, 32'd1, SUM_CMD_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    issue(1, 32'd1, 32'd1, SUM_CMD_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    issue(0, 32'd1, 32'd1, SUM_CMD_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    issue(1, 32'd1, 32'd1, SUM_CMD_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    issue(0, 32'd1, 32'd1, SUM_CMD_ADD, 32'd2, 1'b0, 1'b0, 1'b0, 4'b0000);
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    check("st_grant0", stat_grant_cnt[0], 3);
    check("st_grant1", stat_grant_cnt[1], 2);
    check("st_stall", stat_stall_cnt, 2);
    // Drive requester 0 past the counter limit.
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    repeat (65540) @(posedge clk);
    #1;
    req_valid = '0;
    check("st_sat_grant0", stat_grant_cnt[0], 16'hFFFF);
    check("st_sat_grant1", stat_grant_cnt[1], 2);
    check("st_sat_stall", stat_stall_cnt, 2);
`endif

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
